// File: rtl/demux_pkg.sv
// Shared encodings and sizing for the demux_router result distributor.
package demux_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int NUM_DEST       = 3;

    typedef enum logic [1:0] {
        SEL_OUT0 = 2'd0,
        SEL_OUT1 = 2'd1,
        SEL_OUT2 = 2'd2,
        SEL_DROP = 2'd3
    } sel_e;

endpackage

// File: rtl/demux_router.sv
// Registered 1-to-3 demultiplexer with one holding stage and valid/ready flow control.
// Optional saturating discard counter enabled by defining DEMUX_DROP_CNT_EN.
module demux_router
    import demux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          in_sel,
    output logic [NUM_DEST-1:0] out_valid,
    input  logic [NUM_DEST-1:0] out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]    drop_count
);

    logic              hold_vld_reg,  hold_vld_next;
    sel_e              hold_sel_reg,  hold_sel_next;
    logic [DATA_W-1:0] hold_data_reg, hold_data_next;

    logic [3:0] sel_ready;
    logic       retire;
    logic       accept;

    // The discard slot is always "ready", so a dropped word leaves one cycle after capture.
    assign sel_ready = {1'b1, out_ready};
    assign retire    = hold_vld_reg && sel_ready[hold_sel_reg];
    assign in_ready  = !hold_vld_reg || retire;
    assign accept    = in_valid && in_ready;

    always_comb begin
        hold_vld_next  = hold_vld_reg;
        hold_sel_next  = hold_sel_reg;
        hold_data_next = hold_data_reg;
        if (accept) begin
            hold_vld_next  = 1'b1;
            hold_sel_next  = sel_e'(in_sel);
            hold_data_next = in_data;
        end else if (retire) begin
            hold_vld_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld_reg  <= 1'b0;
            hold_sel_reg  <= SEL_OUT0;
            hold_data_reg <= '0;
        end else begin
            hold_vld_reg  <= hold_vld_next;
            hold_sel_reg  <= hold_sel_next;
            hold_data_reg <= hold_data_next;
        end
    end

    assign out_data = hold_data_reg;

    generate
        for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_out_valid
            assign out_valid[gi] = hold_vld_reg && (hold_sel_reg == 2'(gi));
        end
    endgenerate

`ifdef DEMUX_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (retire && (hold_sel_reg == SEL_DROP) && (drop_cnt_reg != '1)) begin
            drop_cnt_next = drop_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else begin
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign drop_count = drop_cnt_reg;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router: directed scenarios plus randomized traffic against a queue model.
module tb_demux_router;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_sel;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  drop_count;

    int checks;
    int errors;

    demux_router #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected one-hot strobe for a destination select (discard shows nothing).
    function automatic logic [2:0] exp_onehot(input int sel);
        logic [2:0] r;
        r = 3'b000;
        if (sel < 3) r = 3'b001 << sel;
        return r;
    endfunction

    // Expected counter value after n discards have retired.
    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
`ifdef DEMUX_DROP_CNT_EN
        int lim;
        lim = (1 << CNT_W) - 1;
        return (n > lim) ? CNT_W'(lim) : CNT_W'(n);
`else
        return CNT_W'(0 * n);
`endif
    endfunction

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [1:0] s,
                         input logic [2:0] r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        out_ready = r;
        #1;
    endtask

    task automatic apply_reset();
        drive(1'b0, 16'h0000, 2'd0, 3'b000);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF; in_sel = 2'd1; out_ready = 3'b111;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 3'b000 || out_data !== 16'h0000 || drop_count !== '0) begin
                errors++;
                $display("FAIL reset_state cyc%0d got valid=%b data=%h cnt=%h want 000/0000/00",
                         i, out_valid, out_data, drop_count);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        drive(1'b0, 16'h0000, 2'd0, 3'b111);
        checks++;
        if (out_valid !== 3'b010 || out_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL first_accept got valid=%b data=%h want 010/beef", out_valid, out_data);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        apply_reset();
        drive(1'b1, 16'h1234, 2'd2, 3'b111);
        drive(1'b0, 16'h0000, 2'd0, 3'b111);
        checks++;
        if (out_valid !== 3'b100 || out_data !== 16'h1234) begin
            errors++;
            $display("FAIL single_route got valid=%b data=%h want 100/1234", out_valid, out_data);
        end
        drive(1'b0, 16'h0000, 2'd0, 3'b111);
        checks++;
        if (out_valid !== 3'b000) begin
            errors++;
            $display("FAIL single_release got valid=%b want 000", out_valid);
        end
        $display("test_single done");
    endtask

    task automatic test_backpressure();
        apply_reset();
        drive(1'b1, 16'hA5A5, 2'd0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0F0F, 2'd1, 3'b110);
            checks++;
            if (out_valid !== 3'b001 || out_data !== 16'hA5A5 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cyc%0d got valid=%b data=%h rdy=%b want 001/a5a5/0",
                         i, out_valid, out_data, in_ready);
            end
        end
        drive(1'b1, 16'h0F0F, 2'd1, 3'b001);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 3'b001) begin
            errors++;
            $display("FAIL backpressure_release got rdy=%b valid=%b want 1/001", in_ready, out_valid);
        end
        drive(1'b0, 16'h0000, 2'd0, 3'b000);
        checks++;
        if (out_valid !== 3'b010 || out_data !== 16'h0F0F) begin
            errors++;
            $display("FAIL backpressure_second got valid=%b data=%h want 010/0f0f", out_valid, out_data);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(1'b1, DATA_W'(i), 2'(i % 3), 3'b111);
            else       drive(1'b0, 16'h0000, 2'd0, 3'b111);
            if (i > 0) begin
                checks++;
                if (out_valid !== exp_onehot((i - 1) % 3) || out_data !== DATA_W'(i - 1)
                    || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL throughput word%0d got valid=%b data=%h rdy=%b want %b/%h/1",
                             i - 1, out_valid, out_data, in_ready, exp_onehot((i - 1) % 3), i - 1);
                end
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_discard();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DATA_W'(16'hD000 + i), 2'd3, 3'b000);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 3'b000) begin
                errors++;
                $display("FAIL discard_flow word%0d got rdy=%b valid=%b want 1/000", i, in_ready, out_valid);
            end
        end
        drive(1'b0, 16'h0000, 2'd0, 3'b000);
        drive(1'b0, 16'h0000, 2'd0, 3'b000);
        checks++;
        if (drop_count !== exp_cnt(3) || out_valid !== 3'b000) begin
            errors++;
            $display("FAIL discard_count got cnt=%h valid=%b want %h/000", drop_count, out_valid, exp_cnt(3));
        end
        $display("test_discard done");
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 255; i++) drive(1'b1, DATA_W'($urandom), 2'd3, 3'($urandom));
        drive(1'b0, 16'h0000, 2'd0, 3'b000);
        drive(1'b0, 16'h0000, 2'd0, 3'b000);
        checks++;
        if (drop_count !== exp_cnt(255)) begin
            errors++;
            $display("FAIL saturate_255 got %h want %h", drop_count, exp_cnt(255));
        end
        for (int i = 0; i < 5; i++) drive(1'b1, DATA_W'($urandom), 2'd3, 3'b000);
        drive(1'b0, 16'h0000, 2'd0, 3'b000);
        drive(1'b0, 16'h0000, 2'd0, 3'b000);
        checks++;
        if (drop_count !== exp_cnt(260)) begin
            errors++;
            $display("FAIL saturate_hold got %h want %h", drop_count, exp_cnt(260));
        end
        $display("test_saturate done");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1'b1, 16'hCAFE, 2'd1, 3'b000);
        drive(1'b0, 16'h0000, 2'd0, 3'b000);
        checks++;
        if (out_valid !== 3'b010 || out_data !== 16'hCAFE) begin
            errors++;
            $display("FAIL midreset_held got valid=%b data=%h want 010/cafe", out_valid, out_data);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 3'b111;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid !== 3'b000 || drop_count !== '0) begin
                errors++;
                $display("FAIL midreset_drop cyc%0d got valid=%b cnt=%h want 000/00", i, out_valid, drop_count);
            end
            @(negedge clk);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int         q_sel[$];
        logic [DATA_W-1:0] q_data[$];
        int         drops;
        logic       v;
        logic [DATA_W-1:0] d;
        logic [1:0] s;
        logic [2:0] r;
        logic       exp_rdy;
        logic       ret;
        logic [2:0] exp_v;
        apply_reset();
        drops = 0;
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 9) < 7);
            d = DATA_W'($urandom);
            s = 2'($urandom);
            r = 3'($urandom);
            drive(v, d, s, r);
            exp_v = (q_sel.size() != 0) ? exp_onehot(q_sel[0]) : 3'b000;
            ret = (q_sel.size() != 0) && (q_sel[0] == 3 || r[q_sel[0]]);
            exp_rdy = (q_sel.size() == 0) || ret;
            checks++;
            if (out_valid !== exp_v || in_ready !== exp_rdy || drop_count !== exp_cnt(drops)
                || (q_sel.size() != 0 && out_data !== q_data[0])) begin
                errors++;
                $display("FAIL random cyc%0d got valid=%b rdy=%b cnt=%h data=%h want %b/%b/%h/%h",
                         c, out_valid, in_ready, drop_count, out_data, exp_v, exp_rdy, exp_cnt(drops),
                         (q_data.size() != 0) ? q_data[0] : out_data);
            end
            if (ret) begin
                if (q_sel[0] == 3) drops++;
                void'(q_sel.pop_front());
                void'(q_data.pop_front());
            end
            if (v && exp_rdy) begin
                q_sel.push_back(int'(s));
                q_data.push_back(d);
            end
        end
        $display("test_random done drops=%0d", drops);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_discard();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Registered 1-to-3 demultiplexer with valid/ready handshake. It is the distributing counterpart of the datapath selectors.
- Takes one 16-bit result stream tagged with a 2-bit destination select. Delivers each word to exactly one of three consumers (ALU-operand, register-file write-back, memory-store path), or discards it.
- Contains one holding stage and gives full throughput under continuous flow.

Parameters:
- DATA_W, 16, width of data word.
- CNT_W, 8, width of drop counter (used only with optional feature).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  upstream word.
- in_sel  input  2  destination: 0=out0, 1=out1, 2=out2, 3=discard.
- out_valid  output  3  per-destination valid, one-hot or zero.
- out_ready  input  3  per-destination ready.
- out_data  output  DATA_W  shared data bus to all destinations.
- drop_count  output  CNT_W  saturating count of discarded words.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: hold_vld=0, hold_sel=0, out_data=0, out_valid=3'b000, drop_count=0.
- Internal state: hold_vld, hold_sel[1:0], hold_data[DATA_W-1:0]. out_data = hold_data.
- out_valid[k] = hold_vld && hold_sel==k, for k=0..2. Never more than one bit is set.
- Retire condition:
  - retire = hold_vld && (hold_sel==3 || out_ready[hold_sel]).
  - A discard entry (sel 3) retires unconditionally in the cycle after capture.
- in_ready = !hold_vld || retire. This is combinational from out_ready; that path is accepted.
- Accept = in_valid && in_ready. On accept, hold_data/hold_sel load from the inputs and hold_vld=1.
- Retire without accept: hold_vld=0. hold_data keeps its last value; out_data is not cleared.
- Latency: a word accepted in cycle N is presented on out_valid/out_data in cycle N+1.
- Throughput: back-to-back accepts with simultaneous retire sustain 1 word/cycle.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_data and out_valid stay constant. in_ready=0 in that case.
- out_ready bits of non-selected destinations are ignored.
- in_sel and in_data are sampled only on accept. Values while in_valid=0 are don't-care.
- Reset mid-operation: a held word is dropped silently and is not counted as discarded.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro: DEMUX_DROP_CNT_EN.
- Defined:
  - drop_count increments by 1 on each retire with hold_sel==3.
  - It saturates at all-ones and never wraps.
  - It clears only on rst.
- Undefined:
  - No counter flops are built; drop_count is tied to 0.
  - Port list is unchanged.

Decomposition:
- Shared package demux_pkg holds:
  - sel encodings SEL_OUT0=2'd0, SEL_OUT1=2'd1, SEL_OUT2=2'd2, SEL_DROP=2'd3;
  - NUM_DEST=3;
  - default DATA_W=16.
- No sub-module is needed. The holding stage and retire logic stay in demux_router.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid=1, in_data=16'hBEEF, in_sel=1 → out_valid=000, out_data=0, drop_count=0 throughout reset. First accept occurs in the cycle after rst falls.
- Single routing: send 16'h1234 with sel=2, all out_ready=1 → next cycle out_valid=100, out_data=16'h1234. Following cycle out_valid=000.
- Backpressure: send 16'hA5A5 with sel=0 and out_ready[0]=0 for 4 cycles → out_valid=001 and out_data=16'hA5A5 held stable, in_ready=0. A second word 16'h0F0F is presented but not accepted until out_ready[0]=1. It then appears the following cycle.
- Full throughput: stream 8 words 16'h0000..16'h0007 with sel cycling 0,1,2 and all ready → one delivery per cycle, correct one-hot out_valid each cycle, in_ready constantly 1.
- Discard: send 3 words with sel=3 and out_ready=000 → out_valid stays 000 and in_ready stays 1. With the macro, drop_count=3; without it, drop_count=0. Preload 255 discards with CNT_W=8 → count saturates at 8'hFF.
- Reset mid-operation: hold 16'hCAFE at sel=1 with out_ready[1]=0, then pulse rst for 1 cycle → out_valid=000 after reset. The word is never delivered and drop_count is unchanged (0).
